// File: rtl/instr_encoder_loader.sv
// Encodes symbolic instructions into 32-bit words, queues them in a small FIFO
// and writes them to instruction memory at consecutive word addresses.
module instr_encoder_loader #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [31:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              full, empty, accept, push, pop;

  assign full   = (occ == OCC_W'(DEPTH));
  assign empty  = (occ == '0);
  assign accept = cmd_valid & cmd_ready;
  assign push   = accept & enc_legal;
  assign pop    = mem_we & mem_ready;

  // Instruction word encoding; ops 13-15 are flagged illegal
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (cmd_op)
      4'd0:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b100000};
      4'd1:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b010000};
      4'd2:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b001000};
      4'd3:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b000100};
      4'd4:    enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b0, 6'b000010};
      4'd5:    enc_word = {6'b001111, cmd_rs, cmd_rt, cmd_imm};
      4'd6:    enc_word = {6'b111111, cmd_rs, cmd_rt, cmd_imm};
      4'd7:    enc_word = {6'b111100, cmd_rs, cmd_rt, cmd_imm};
      4'd8:    enc_word = {6'b111110, cmd_rs, cmd_rt, cmd_imm};
      4'd9:    enc_word = {6'b011111, cmd_rs, cmd_rt, cmd_imm};
      4'd10:   enc_word = {6'b000001, cmd_target};
      4'd11:   enc_word = {6'b000111, cmd_target};
      4'd12:   enc_word = {6'b000011, cmd_rs, 21'b0};
      default: enc_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && cmd_last) state_nxt = DRAIN;
      DRAIN:   if (empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD: begin
        cmd_ready = !full;
        mem_we    = !empty;
        busy      = 1'b1;
      end
      DRAIN: begin
        mem_we = !empty;
        busy   = 1'b1;
        done   = empty;
      end
      default: ;
    endcase
  end

  // Head is masked while empty so the write port reads zero, not stale storage
  assign mem_addr  = addr;
  assign mem_wdata = empty ? 32'd0 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      addr   <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        addr  <= base_addr;
        count <= '0;
        err   <= 1'b0;
      end
      if (accept && !enc_legal) err <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        addr   <= addr + ADDR_W'(4);
        if (count != 16'hFFFF) count <= count + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: the driver queues expected memory
// writes, a monitor pops and compares them on each accepted write.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, cmd_valid, cmd_ready, cmd_last;
  logic [31:0] base_addr, mem_addr, mem_wdata;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm, count;
  logic [25:0] cmd_target;
  logic        mem_we, mem_ready, busy, done, err;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] exp_addr;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
    .cmd_target(cmd_target), .cmd_last(cmd_last), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted memory write must match the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_we && mem_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got %h:%h expected none", mem_addr, mem_wdata);
        end else begin
          e = sb_q.pop_front();
          if (mem_addr !== e.addr || mem_wdata !== e.data) begin
            errors++;
            $display("FAIL mem_write: got %h:%h expected %h:%h",
                     mem_addr, mem_wdata, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // All tasks begin and end 1 time unit after a rising edge
  task automatic do_start(input logic [31:0] b);
    start     = 1'b1;
    base_addr = b;
    exp_addr  = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic last, input logic legal, input logic [31:0] word);
    exp_t e;
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_imm = imm; cmd_target = tgt; cmd_last = last; cmd_valid = 1'b1;
    if (legal) begin
      e.addr = exp_addr;
      e.data = word;
      sb_q.push_back(e);
      exp_addr = exp_addr + 32'd4;
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_last  = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic [15:0] exp_count, input logic exp_err);
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
    chk({name, "_count"}, 32'(count), 32'(exp_count));
    chk({name, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; cmd_valid = 1'b0; cmd_op = '0;
    cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_imm = '0; cmd_target = '0;
    cmd_last = 1'b0; mem_ready = 1'b0; exp_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_outputs", {mem_we, cmd_ready, busy, done, err}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1;

    // 1: single R-type
    mem_ready = 1'b1;
    do_start(32'h40);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0022_1820);
    wait_done("t1", 16'd1, 1'b0);

    // 2: I-type pair
    do_start(32'h40);
    send(4'd5, 5'd0, 5'd5, 5'd0, 16'hFFFF, 26'h0, 1'b0, 1'b1, 32'h3C05_FFFF);
    send(4'd9, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0, 1'b1, 1'b1, 32'h7C22_0003);
    wait_done("t2", 16'd2, 1'b0);

    // 3: jumps
    do_start(32'h80);
    send(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b0, 1'b1, 32'h0400_0010);
    send(4'd12, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0FE0_0000);
    wait_done("t3", 16'd2, 1'b0);

    // 4: backpressure fills the FIFO, then drains in order
    mem_ready = 1'b0;
    do_start(32'h200);
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0085_3010);
    send(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b0, 1'b1, 32'h00E8_4808);
    send(4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0021_0804);
    send(4'd4, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0043_2002);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_full_ready", 32'(cmd_ready), 32'd0);
      chk("t4_hold_addr", mem_addr, 32'h200);
      chk("t4_hold_data", mem_wdata, 32'h0085_3010);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    send(4'd6, 5'd3, 5'd4, 5'd0, 16'h8000, 26'h0, 1'b0, 1'b1, 32'hFC64_8000);
    send(4'd7, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 1'b1, 32'hF3A8_0004);
    wait_done("t4", 16'd6, 1'b0);

    // 5: illegal op is swallowed and flagged
    do_start(32'h300);
    send(4'd8, 5'd29, 5'd9, 5'd0, 16'h0008, 26'h0, 1'b0, 1'b1, 32'hFBA9_0008);
    send(4'd13, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b0, 1'b0, 32'h0);
    send(4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b1, 1'b1, 32'h1FFF_FFFF);
    wait_done("t5", 16'd2, 1'b1);

    // 6: address wrap, then reset in the middle of a session
    do_start(32'hFFFF_FFFC);
    @(negedge clk);
    chk("t6_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1820);
    send(4'd3, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b1, 1'b1, 32'h0021_0804);
    wait_done("t6", 16'd2, 1'b0);

    mem_ready = 1'b0;
    do_start(32'h100);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0, 1'b1, 32'h0022_1820);
    @(negedge clk);
    chk("t6_pre_rst_we", 32'(mem_we), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_rst_we", 32'(mem_we), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
